// File: rtl/dpram_pkg.sv
// Shared types and default constants for the parametrised dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int              DEF_DW    = 8;
    localparam int              DEF_AW    = 4;
    localparam int              DEF_DEPTH = 16;
    localparam logic [DEF_DW-1:0] DEF_FILL = '0;

endpackage

// File: rtl/dpram_core.sv
// Bare memory array: synchronous write port and a registered, write-first read port.
// Reads beyond DEPTH return FILL; the caller gates writes to in-range addresses.
module dpram_core
    import dpram_pkg::*;
#(
    parameter int            DW    = DEF_DW,
    parameter int            AW    = DEF_AW,
    parameter int            DEPTH = DEF_DEPTH,
    parameter logic [DW-1:0] FILL  = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata_p0;
    logic          w_rd_inrange;

    assign w_rd_inrange = ({1'b0, i_raddr} < LP_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // stage 0: read register, holds its value when no read is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata_p0 <= '0;
        end else if (i_re) begin
            if (!w_rd_inrange) begin
                r_rdata_p0 <= FILL;
            end else if (i_we && (i_waddr == i_raddr)) begin
                r_rdata_p0 <= i_wdata;
            end else begin
                r_rdata_p0 <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata_p0;

endmodule

// File: rtl/dpram_param.sv
// Parametrised single-clock dual-port RAM with FILL clear sweep after reset or clr.
// Define DPRAM_OUT_REG_EN to add a second output register (read latency 2).
module dpram_param
    import dpram_pkg::*;
#(
    parameter int            DW    = DEF_DW,
    parameter int            AW    = DEF_AW,
    parameter int            DEPTH = DEF_DEPTH,
    parameter logic [DW-1:0] FILL  = DW'(DEF_FILL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr_wr,
    input  logic [DW-1:0] data_in,
    input  logic          re,
    input  logic [AW-1:0] addr_rd,
    input  logic          clr,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          busy
);

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_sweep_ptr;
    logic [AW-1:0] w_sweep_ptr_nxt;
    logic          w_run;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_core_we;
    logic [AW-1:0] w_core_waddr;
    logic [DW-1:0] w_core_wdata;
    logic [DW-1:0] w_rdata_p0;
    logic          r_vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SWEEP;
            r_sweep_ptr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_ptr <= w_sweep_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_ptr_nxt = r_sweep_ptr;
        case (r_state)
            SWEEP: begin
                if (r_sweep_ptr == LP_LAST) begin
                    w_state_nxt     = RUN;
                    w_sweep_ptr_nxt = '0;
                end else begin
                    w_sweep_ptr_nxt = r_sweep_ptr + AW'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    w_state_nxt     = SWEEP;
                    w_sweep_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = SWEEP;
                w_sweep_ptr_nxt = '0;
            end
        endcase
    end

    // A clr cycle swallows any access presented alongside it
    assign w_run   = (r_state == RUN);
    assign w_wr_en = w_run && !clr && we && ({1'b0, addr_wr} < LP_DEPTH);
    assign w_rd_en = w_run && !clr && re;

    // The sweep borrows the write port while not in RUN
    assign w_core_we    = !w_run || w_wr_en;
    assign w_core_waddr = w_run ? addr_wr : r_sweep_ptr;
    assign w_core_wdata = w_run ? data_in : FILL;

    dpram_core #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH),
        .FILL  (FILL)
    ) u_core (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_rd_en),
        .i_raddr (addr_rd),
        .o_rdata (w_rdata_p0)
    );

    // stage 0: valid travels with the core read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_rd_en;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DW-1:0] r_data_p1;
    logic          r_vld_p1;

    // stage 1: extra output register; a result already in flight survives clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_data_p1 <= w_rdata_p0;
            r_vld_p1  <= r_vld_p0;
        end
    end

    assign data_out = r_data_p1;
    assign rd_valid = r_vld_p1;
`else
    assign data_out = w_rdata_p0;
    assign rd_valid = r_vld_p0;
`endif

    assign busy = !w_run;

endmodule
